// File: rtl/collision_detect.sv
// collision_detect: per-frame bird/wall collision and scoring detector.
// On an accepted frame tick the bird row is captured and every wall entry of
// the position store is fetched and evaluated, one index per cycle. The frame
// result is published as a one-cycle done/score pulse plus a sticky collision.
module collision_detect #(
    parameter int NUM_WALLS = 4,
    parameter int BIRD_X    = 20,
    parameter int BIRD_W    = 8,
    parameter int BIRD_H    = 8,
    parameter int WALL_W    = 10,
    parameter int GAP_H     = 40,
    parameter int SCREEN_H  = 120,
    localparam int SEL_W    = (NUM_WALLS > 2) ? $clog2(NUM_WALLS) : 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable,
    input  logic             frame_tick,
    input  logic             clear,
    input  logic [6:0]       bird_y,
    output logic [SEL_W-1:0] wall_sel,
    input  logic [7:0]       wall_x,
    input  logic [6:0]       wall_gap_y,
    output logic             busy,
    output logic             done,
    output logic             score,
    output logic             collision,
    output logic             overrun
);

    typedef enum logic [1:0] {IDLE, SCAN, FIN} state_t;

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_WALLS - 1);

    state_t           state_q;
    state_t           state_d;
    logic [6:0]       bird_y_q;
    logic             vld_p0;
    logic             vld_p1;
    logic [SEL_W-1:0] idx_p1;
    logic             hit_acc;
    logic             pass_acc;
    logic             start;
    logic             last_eval;

    // Bird touches the top row or extends past the bottom of the screen.
    function automatic logic bounds_hit(input logic [6:0] y);
        logic [8:0] bot;
        bot = {2'b00, y} + 9'(BIRD_H);
        return (y == 7'd0) || (bot > 9'(SCREEN_H));
    endfunction

    // Bird overlaps the wall horizontally and is outside the gap vertically.
    function automatic logic wall_hit(input logic [6:0] y, input logic [7:0] wx,
                                      input logic [6:0] gy);
        logic [8:0] w_left;
        logic [8:0] w_right;
        logic [8:0] b_top;
        logic [8:0] b_bot;
        logic [8:0] g_top;
        logic [8:0] g_bot;
        logic       h_ovl;
        logic       v_hit;
        w_left  = {1'b0, wx};
        w_right = w_left + 9'(WALL_W);
        b_top   = {2'b00, y};
        b_bot   = b_top + 9'(BIRD_H);
        g_top   = {2'b00, gy};
        g_bot   = g_top + 9'(GAP_H);
        h_ovl   = (w_left < 9'(BIRD_X + BIRD_W)) && (w_right > 9'(BIRD_X));
        v_hit   = (b_top < g_top) || (b_bot > g_bot);
        return h_ovl && v_hit;
    endfunction

    // Wall's right edge sits exactly on the bird's left column this frame.
    function automatic logic wall_passed(input logic [7:0] wx);
        return ({1'b0, wx} + 9'(WALL_W)) == 9'(BIRD_X);
    endfunction

    assign start     = (state_q == IDLE) && frame_tick && enable && !clear;
    assign last_eval = vld_p1 && (idx_p1 == LAST_SEL);

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clear always returns to IDLE.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = SCAN;
                SCAN:    if (last_eval) state_d = FIN;
                FIN:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Busy covers the whole scan including the FIN cycle.
    always_comb begin
        busy = (state_q != IDLE);
    end

    // Control path: index issue, valid pipe, accumulators and result flags.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wall_sel  <= '0;
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            hit_acc   <= 1'b0;
            pass_acc  <= 1'b0;
            done      <= 1'b0;
            score     <= 1'b0;
            collision <= 1'b0;
            overrun   <= 1'b0;
        end else if (clear) begin
            wall_sel  <= '0;
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            hit_acc   <= 1'b0;
            pass_acc  <= 1'b0;
            done      <= 1'b0;
            score     <= 1'b0;
            collision <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            done  <= 1'b0;
            score <= 1'b0;
            if (frame_tick && (state_q != IDLE)) overrun <= 1'b1;
            // p0 -> p1: index issued last cycle, its store data is now present
            vld_p1 <= vld_p0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        wall_sel <= '0;
                        vld_p0   <= 1'b1;
                        hit_acc  <= bounds_hit(bird_y);
                        pass_acc <= 1'b0;
                    end
                end
                SCAN: begin
                    if (wall_sel != LAST_SEL) wall_sel <= wall_sel + 1'b1;
                    else                      vld_p0   <= 1'b0;
                    if (vld_p1) begin
                        hit_acc  <= hit_acc  | wall_hit(bird_y_q, wall_x, wall_gap_y);
                        pass_acc <= pass_acc | wall_passed(wall_x);
                    end
                end
                FIN: begin
                    done  <= 1'b1;
                    score <= pass_acc && !hit_acc && !collision;
                    if (hit_acc) collision <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Data path: captured bird row and the index that travels with vld_p1.
    always_ff @(posedge clk) begin
        if (start) bird_y_q <= bird_y;
        idx_p1 <= wall_sel;
    end

endmodule
